sha256_msg_schedule: RTL and testbench
======================================

Name: sha256_msg_schedule

Overview:
Sequential SHA-256 message-schedule generator. It is the producer that feeds the per-round compression datapath with W_t. It accepts one 512-bit padded block over a valid/ready handshake, then emits W_0..W_63 one word per handshake on a valid/ready stream, using a 16-word sliding window. It sits between block padding/buffering and the round datapath, which pairs each W_t with K_t.

Parameters:
BIT_W, 32, word width. Only 32 is supported; the sigma functions are defined for 32 bits.
ROUNDS, 64, number of schedule words emitted per block.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
blk_valid  input  1  upstream block offered
blk_ready  output  1  block can be accepted
blk_data  input  16*BIT_W  message block; word 0 at [511:480], word 15 at [31:0]
w_valid  output  1  W_t valid
w_ready  input  1  downstream accepts W_t
w_out  output  BIT_W  schedule word W_t
w_round  output  6  index t of w_out
w_last  output  1  high when w_round == ROUNDS-1 and w_valid
busy  output  1  high in RUN state

Behaviour:
- State machine has two states, IDLE and RUN.
- State is a register. Window win[0..15] holds BIT_W each. Round counter cnt is 6 bits.
- Reset (synchronous, takes effect at the clk edge while reset is high):
  - state=IDLE, cnt=0, win[*]=0.
  - w_valid=0, w_last=0, busy=0, w_out=0, w_round=0.
  - blk_ready=0 while reset is high; it is 1 the cycle after reset deasserts.
- Reset mid-operation aborts the block. No partial words are emitted afterwards.
- IDLE:
  - blk_ready=1, w_valid=0.
  - On blk_valid&&blk_ready: win[i]=blk_data word i, cnt=0, go to RUN.
- RUN:
  - blk_ready=0; blk_valid is ignored.
  - w_valid=1, w_out=win[0], w_round=cnt, busy=1.
- Word handshake (w_valid&&w_ready):
  - win[i]=win[i+1] for i=0..14.
  - win[15]=sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0], computed modulo 2^32 (carries discarded).
  - cnt=cnt+1.
  - If cnt==ROUNDS-1 at the handshake, go to IDLE and set cnt=0.
- Stall (w_valid && !w_ready): w_out, w_round, w_last and the window hold unchanged. Stalls may last any number of cycles.
- Function definitions:
  - sigma0(x)=ROTR7(x)^ROTR18(x)^SHR3(x).
  - sigma1(x)=ROTR17(x)^ROTR19(x)^SHR10(x).
- Latency and throughput:
  - Block accepted at edge N gives w_valid=1 with W_0 in cycle N+1.
  - With w_ready held at 1, W_t appears in cycle N+1+t.
  - The last handshake at edge M gives blk_ready=1 in cycle M+1.
  - One idle cycle between blocks minimum; a block takes 65 cycles.
- Word sources: W_0..W_15 equal the input words unchanged; computed words begin at W_16.
- All outputs are driven from registers or from state/window registers only. There is no combinational path from w_ready to w_valid or to w_out, and none from blk_valid to blk_ready.
- Simultaneous blk_valid with the final word handshake: the block is not accepted that cycle (blk_ready=0); it is accepted next cycle if still offered.

Test Plan:
- Reset check: assert reset 2 cycles with random inputs -> w_valid=0, busy=0, blk_ready=0 during reset; blk_ready=1 the first cycle after.
- "abc" block (word0=0x61626380, words1-14=0, word15=0x00000018), w_ready=1 -> W_0=0x61626380, W_15=0x00000018, W_16=0x61626380, W_17=0x000F0000.
  - Exactly 64 handshakes, w_round 0..63.
  - w_last only with w_round=63.
  - blk_ready=1 the cycle after.
- All-ones block (every word 0xFFFFFFFF) -> W_0..W_15=0xFFFFFFFF, W_16=0x203FFFFC (checks the modulo-2^32 wrap).
- Backpressure: "abc" block with random w_ready (about 50%) -> identical W sequence to the second scenario; w_out and w_round stable across every stall cycle; no word skipped or duplicated.
- Protocol: hold blk_valid=1 with changing blk_data throughout RUN -> blk_ready=0 and the sequence is unaffected.
  - The next block is accepted only the cycle after the W_63 handshake.
  - Its W_0 matches the blk_data present at acceptance.
- Reset mid-run: assert reset after the W_20 handshake -> next cycle w_valid=0, busy=0.
  - After deassertion, a new block restarts at w_round=0 with correct W_0..W_63 checked against a software model.

Source files
------------

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule producer: accepts one 512-bit block, then streams
// W_0..W_63 from a 16-word sliding window, one word per valid/ready handshake.
module sha256_msg_schedule #(
  parameter int unsigned BIT_W  = 32,
  parameter int unsigned ROUNDS = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  blk_valid,
  output logic                  blk_ready,
  input  logic [16*BIT_W-1:0]   blk_data,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [BIT_W-1:0]      w_out,
  output logic [5:0]            w_round,
  output logic                  w_last,
  output logic                  busy
);

  localparam int unsigned CNT_W = 6;
  localparam int unsigned WIN_N = 16;
  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);
  localparam logic [CNT_W-1:0] PENULT_RND = CNT_W'(ROUNDS - 2);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [BIT_W-1:0]  win [WIN_N];
  logic [BIT_W-1:0]  w_next;

  function automatic logic [BIT_W-1:0] sig0(input logic [BIT_W-1:0] x);
    return {x[6:0], x[BIT_W-1:7]} ^ {x[17:0], x[BIT_W-1:18]} ^ (x >> 3);
  endfunction

  function automatic logic [BIT_W-1:0] sig1(input logic [BIT_W-1:0] x);
    return {x[16:0], x[BIT_W-1:17]} ^ {x[18:0], x[BIT_W-1:19]} ^ (x >> 10);
  endfunction

  // Word entering the window tail: W_{t+16} from the current window (W_t at win[0]).
  assign w_next = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

  // The presented word and its index are the window head and the round counter.
  assign w_out   = win[0];
  assign w_round = cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      blk_ready <= 1'b0;
      w_valid   <= 1'b0;
      w_last    <= 1'b0;
      busy      <= 1'b0;
      for (int i = 0; i < WIN_N; i++) begin
        win[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          blk_ready <= 1'b1;
          if (blk_valid && blk_ready) begin
            for (int i = 0; i < WIN_N; i++) begin
              win[i] <= blk_data[(WIN_N-i)*BIT_W-1 -: BIT_W];
            end
            cnt       <= '0;
            state     <= RUN;
            blk_ready <= 1'b0;
            w_valid   <= 1'b1;
            busy      <= 1'b1;
            w_last    <= (LAST_RND == '0);
          end
        end
        RUN: begin
          if (w_ready) begin
            for (int i = 0; i < WIN_N-1; i++) begin
              win[i] <= win[i+1];
            end
            win[WIN_N-1] <= w_next;
            if (cnt == LAST_RND) begin
              // Final word consumed; ready for a new block next cycle.
              state     <= IDLE;
              cnt       <= '0;
              w_valid   <= 1'b0;
              busy      <= 1'b0;
              w_last    <= 1'b0;
              blk_ready <= 1'b1;
            end else begin
              cnt    <= cnt + CNT_W'(1);
              w_last <= (cnt == PENULT_RND);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule against a software SHA-256
// schedule model, with randomized blocks, backpressure and protocol abuse.
module tb_sha256_msg_schedule;

  logic         clk = 1'b0;
  logic         reset;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_out;
  logic [5:0]   w_round;
  logic         w_last;
  logic         busy;

  int checks = 0;
  int failures = 0;

  logic [31:0] blk_w [16];
  logic [31:0] exp_w [64];
  logic [31:0] got_w [64];

  always #5 clk = ~clk;

  sha256_msg_schedule #(.BIT_W(32), .ROUNDS(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_out     (w_out),
    .w_round   (w_round),
    .w_last    (w_last),
    .busy      (busy)
  );

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Textbook schedule expansion over the full 64-entry array.
  task automatic build_model();
    for (int t = 0; t < 64; t++) begin
      if (t < 16) exp_w[t] = blk_w[t];
      else exp_w[t] = s1(exp_w[t-2]) + exp_w[t-7] + s0(exp_w[t-15]) + exp_w[t-16];
    end
  endtask

  function automatic logic [511:0] pack_block();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[511-32*i -: 32] = blk_w[i];
    return d;
  endfunction

  task automatic random_block();
    for (int i = 0; i < 16; i++) blk_w[i] = $urandom();
  endtask

  task automatic abc_block();
    for (int i = 0; i < 16; i++) blk_w[i] = 32'h0;
    blk_w[0]  = 32'h61626380;
    blk_w[15] = 32'h00000018;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_block();
    int n = 0;
    while (blk_ready !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (blk_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready: blk_ready=%b after %0d cycles, want 1", blk_ready, n);
    end
    blk_data  = pack_block();
    blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
    checks++;
    if ({w_valid, busy, blk_ready, w_round, w_out} !== {1'b1, 1'b1, 1'b0, 6'd0, blk_w[0]}) begin
      failures++;
      $display("FAIL accept: v=%b busy=%b rdy=%b round=%0d w=%h, want v=1 busy=1 rdy=0 round=0 w=%h",
               w_valid, busy, blk_ready, w_round, w_out, blk_w[0]);
    end
  endtask

  // Consume words until stop_at handshakes; every cycle checks the presented word.
  task automatic run_words(input int rdy_pct, input bit churn, input int stop_at, output int cycles);
    int  idx = 0;
    bit  rdy;
    cycles = 0;
    while (idx < stop_at && cycles < 2000) begin
      checks++;
      if ({w_valid, busy, blk_ready, w_last, w_round, w_out} !==
          {1'b1, 1'b1, 1'b0, (idx == 63), 6'(idx), exp_w[idx]}) begin
        failures++;
        $display("FAIL word[%0d]: v=%b busy=%b rdy=%b last=%b round=%0d w=%h, want v=1 busy=1 rdy=0 last=%b round=%0d w=%h",
                 idx, w_valid, busy, blk_ready, w_last, w_round, w_out, (idx == 63), idx, exp_w[idx]);
      end
      got_w[idx] = w_out;
      rdy = ($urandom_range(99) < rdy_pct);
      w_ready = rdy;
      if (churn) begin
        blk_valid = 1'b1;
        for (int j = 0; j < 16; j++) blk_data[j*32 +: 32] = $urandom();
      end
      tick();
      cycles++;
      if (rdy) idx++;
    end
    w_ready = 1'b0;
    checks++;
    if (idx < stop_at) begin
      failures++;
      $display("FAIL run_timeout: %0d handshakes in %0d cycles, want %0d", idx, cycles, stop_at);
    end
    if (stop_at == 64) begin
      checks++;
      if ({w_valid, busy, blk_ready, w_last} !== 4'b0010) begin
        failures++;
        $display("FAIL block_end: v=%b busy=%b rdy=%b last=%b, want v=0 busy=0 rdy=1 last=0",
                 w_valid, busy, blk_ready, w_last);
      end
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    blk_valid = 1'($urandom());
    w_ready   = 1'($urandom());
    for (int j = 0; j < 16; j++) blk_data[j*32 +: 32] = $urandom();
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({w_valid, busy, blk_ready} !== 3'b000) begin
        failures++;
        $display("FAIL reset_hold[%0d]: v=%b busy=%b rdy=%b, want 000", k, w_valid, busy, blk_ready);
      end
    end
    reset     = 1'b0;
    blk_valid = 1'b0;
    w_ready   = 1'b0;
    tick();
    checks++;
    if ({blk_ready, w_valid, busy} !== 3'b100) begin
      failures++;
      $display("FAIL reset_release: rdy=%b v=%b busy=%b, want rdy=1 v=0 busy=0", blk_ready, w_valid, busy);
    end
  endtask

  task automatic test_abc();
    int cyc;
    abc_block();
    build_model();
    send_block();
    run_words(100, 1'b0, 64, cyc);
    checks++;
    if (cyc !== 64) begin
      failures++;
      $display("FAIL abc_throughput: %0d cycles, want 64", cyc);
    end
    checks++;
    if ({got_w[0], got_w[15], got_w[16], got_w[17]} !==
        {32'h61626380, 32'h00000018, 32'h61626380, 32'h000F0000}) begin
      failures++;
      $display("FAIL abc_known: W0=%h W15=%h W16=%h W17=%h, want 61626380 00000018 61626380 000f0000",
               got_w[0], got_w[15], got_w[16], got_w[17]);
    end
  endtask

  task automatic test_all_ones();
    int cyc;
    for (int i = 0; i < 16; i++) blk_w[i] = 32'hFFFFFFFF;
    build_model();
    send_block();
    run_words(100, 1'b0, 64, cyc);
    checks++;
    if (got_w[16] !== 32'h203FFFFC) begin
      failures++;
      $display("FAIL ones_wrap: W16=%h, want 203ffffc", got_w[16]);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    abc_block();
    build_model();
    send_block();
    run_words(50, 1'b0, 64, cyc);
  endtask

  task automatic test_back_to_back();
    int cyc;
    random_block();
    build_model();
    send_block();
    run_words(100, 1'b1, 64, cyc);
    // blk_valid is still high: the new block must be taken at this very edge.
    random_block();
    build_model();
    blk_data = pack_block();
    tick();
    blk_valid = 1'b0;
    checks++;
    if ({w_valid, w_round, w_out} !== {1'b1, 6'd0, blk_w[0]}) begin
      failures++;
      $display("FAIL b2b_accept: v=%b round=%0d w=%h, want v=1 round=0 w=%h",
               w_valid, w_round, w_out, blk_w[0]);
    end
    run_words(70, 1'b0, 64, cyc);
  endtask

  task automatic test_reset_midrun();
    int cyc;
    random_block();
    build_model();
    send_block();
    run_words(70, 1'b0, 21, cyc);
    reset = 1'b1;
    tick();
    checks++;
    if ({w_valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL midrun_reset: v=%b busy=%b, want 00", w_valid, busy);
    end
    reset = 1'b0;
    random_block();
    build_model();
    send_block();
    run_words(100, 1'b0, 64, cyc);
  endtask

  initial begin
    reset     = 1'b1;
    blk_valid = 1'b0;
    w_ready   = 1'b0;
    blk_data  = '0;
    test_reset();
    test_abc();
    test_all_ones();
    test_backpressure();
    test_back_to_back();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
